// File: rtl/i2c_master_line_driver_pkg.sv
// Shared I2C definitions: command opcodes, line-driver FSM states and line-drive payload.
// The controller sequencer imports the same opcodes.
package i2c_master_line_driver_pkg;

  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned QIDX_W    = 2;

  typedef enum logic [1:0] {
    I2C_OP_NOP   = 2'd0,
    I2C_OP_START = 2'd1,
    I2C_OP_WRITE = 2'd2,
    I2C_OP_STOP  = 2'd3
  } i2c_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_START  = 3'd2,
    ST_RSTART = 3'd3,
    ST_BIT    = 3'd4,
    ST_ACK    = 3'd5,
    ST_STOP   = 3'd6
  } i2c_state_e;

  // Open-drain pull-down enables, 1 = pull low
  typedef struct packed {
    logic scl;
    logic sda;
  } i2c_lines_t;

endpackage

// File: rtl/i2c_master_line_driver_quarter_timer.sv
// Quarter-bit timer: counts 0..QUARTER_PERIOD-1 while running, ticks on wrap.
// The count is held at 0 when not running and frozen while the slave stretches SCL.
module i2c_master_line_driver_quarter_timer #(
  parameter int unsigned QUARTER_PERIOD = 125,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic freeze,
  output logic tick_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(QUARTER_PERIOD - 1);

  logic [CNT_W-1:0] count;

  assign tick_c = run && !freeze && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!freeze) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_line_driver.sv
// I2C transmit line driver: turns START / WRITE / STOP commands into open-drain SCL/SDA
// drive, samples the slave ACK and honours clock stretching.
module i2c_master_line_driver
  import i2c_master_line_driver_pkg::*;
#(
  parameter int unsigned QUARTER_PERIOD = 125,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       fast_clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       done,
  output logic       ack_n,
  output logic       cmd_error,
  output logic       bus_owned
);

  i2c_state_e           state_q, state_d;
  logic [QIDX_W-1:0]    quarter_q, quarter_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  i2c_lines_t           lines_q, lines_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ack_smp_q, ack_smp_d;
  logic                 ack_n_q, ack_n_d;
  logic                 owned_q, owned_d;
  logic                 tick_q;
  logic                 tick_c;
  logic                 run_c;
  logic                 freeze_c;
  logic                 accept_c;
  i2c_op_e              op_c;

  assign run_c    = (state_q != ST_IDLE) && (state_q != ST_HOLD);
  // A released SCL that still reads low means the slave is stretching
  assign freeze_c = !lines_q.scl && !scl_in;
  assign accept_c = cmd_valid && ready_q;
  assign op_c     = i2c_op_e'(cmd_op);

  i2c_master_line_driver_quarter_timer #(
    .QUARTER_PERIOD (QUARTER_PERIOD),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk    (fast_clock),
    .rst_n  (reset_n),
    .run    (run_c),
    .freeze (freeze_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge fast_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      quarter_q <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      lines_q   <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_smp_q <= 1'b1;
      ack_n_q   <= 1'b1;
      owned_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      lines_q   <= lines_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_smp_q <= ack_smp_d;
      ack_n_q   <= ack_n_d;
      owned_q   <= owned_d;
      tick_q    <= tick_c;
    end
  end

  // Next state; line drive is computed for the quarter being entered so outputs stay registered
  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    lines_d   = lines_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ack_smp_d = ack_smp_q;
    ack_n_d   = ack_n_q;
    owned_d   = owned_q;

    case (state_q)
      ST_IDLE: begin
        lines_d = '0;
        if (accept_c) begin
          case (op_c)
            I2C_OP_START: begin
              state_d     = ST_START;
              quarter_d   = '0;
              lines_d.sda = 1'b1;
            end
            I2C_OP_WRITE, I2C_OP_STOP: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_HOLD: begin
        if (accept_c) begin
          quarter_d = '0;
          case (op_c)
            I2C_OP_WRITE: begin
              state_d = ST_BIT;
              bit_d   = BIT_CNT_W'(7);
              shift_d = cmd_data;
            end
            I2C_OP_START: begin
              state_d     = ST_RSTART;
              lines_d.sda = 1'b0;
            end
            I2C_OP_STOP: begin
              state_d     = ST_STOP;
              lines_d.sda = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_START: begin
        if (tick_c) begin
          quarter_d = quarter_q + QIDX_W'(1);
          if (quarter_q == QIDX_W'(0)) begin
            lines_d.scl = 1'b1;
          end else begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
            owned_d = 1'b1;
          end
        end
      end

      ST_RSTART: begin
        if (tick_c) begin
          quarter_d = quarter_q + QIDX_W'(1);
          case (quarter_q)
            2'd0:    lines_d.scl = 1'b0;
            2'd1:    lines_d.sda = 1'b1;
            2'd2:    lines_d.scl = 1'b1;
            default: begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
            end
          endcase
        end
      end

      ST_BIT: begin
        // SDA follows one cycle after SCL is pulled low so the two never move together
        if (lines_q.scl) lines_d.sda = ~shift_q[7];
        if (tick_c) begin
          quarter_d = quarter_q + QIDX_W'(1);
          if (quarter_q == QIDX_W'(1)) begin
            lines_d.scl = 1'b0;
          end else if (quarter_q == QIDX_W'(3)) begin
            lines_d.scl = 1'b1;
            if (bit_q == '0) begin
              state_d = ST_ACK;
            end else begin
              bit_d   = bit_q - BIT_CNT_W'(1);
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
      end

      ST_ACK: begin
        if (lines_q.scl) lines_d.sda = 1'b0;
        if (tick_q && (quarter_q == QIDX_W'(3))) ack_smp_d = sda_in;
        if (tick_c) begin
          quarter_d = quarter_q + QIDX_W'(1);
          if (quarter_q == QIDX_W'(1)) begin
            lines_d.scl = 1'b0;
          end else if (quarter_q == QIDX_W'(3)) begin
            lines_d.scl = 1'b1;
            state_d     = ST_HOLD;
            done_d      = 1'b1;
            ack_n_d     = ack_smp_q;
          end
        end
      end

      ST_STOP: begin
        if (tick_c) begin
          quarter_d = quarter_q + QIDX_W'(1);
          case (quarter_q)
            2'd0:    lines_d.scl = 1'b0;
            2'd1:    lines_d.sda = 1'b0;
            default: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              owned_d = 1'b0;
            end
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
  end

  assign scl_oe    = lines_q.scl;
  assign sda_oe    = lines_q.sda;
  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign cmd_error = err_q;
  assign ack_n     = ack_n_q;
  assign bus_owned = owned_q;

endmodule

// File: tb/tb_i2c_master_line_driver.sv
// Directed bench for the I2C line driver: models the wired-AND bus with a slave that can ACK
// and stretch SCL, and checks timing, bit patterns, bus conditions and handshake.
module tb_i2c_master_line_driver;

  localparam int QP    = 10;
  localparam int LIMIT = 5000;
  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  logic       fast_clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic       done;
  logic       ack_n;
  logic       cmd_error;
  logic       bus_owned;
  logic       stretch;
  logic       slave_low;

  int checks   = 0;
  int failures = 0;

  int         r_cyc, r_starts, r_stops, r_viol, r_busy_ready, r_owned_low;
  logic [7:0] r_bits;
  logic       r_err, r_any_oe, r_done;

  assign scl_in = ~scl_oe & ~stretch;
  assign sda_in = ~sda_oe & ~slave_low;

  always #5 fast_clock = ~fast_clock;

  i2c_master_line_driver #(
    .QUARTER_PERIOD (QP),
    .CNT_W          (8)
  ) dut (
    .fast_clock (fast_clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .done       (done),
    .ack_n      (ack_n),
    .cmd_error  (cmd_error),
    .bus_owned  (bus_owned)
  );

  // Issue one command and observe the bus until DONE; results land in the r_* variables
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic ack,
                         input int stretch_at, input int stretch_len, input logic hold,
                         input logic [1:0] nxt_op, input logic [7:0] nxt_data);
    int w, rise, fall, left;
    logic pscl, psda;
    r_cyc = 0; r_bits = '0; r_starts = 0; r_stops = 0; r_viol = 0;
    r_busy_ready = 0; r_owned_low = 0; r_err = 1'b0; r_any_oe = 1'b0; r_done = 1'b0;
    rise = 0; fall = 0; left = 0;
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < LIMIT) begin
      @(negedge fast_clock);
      w++;
    end
    if (cmd_ready) begin
      pscl = scl_oe;
      psda = sda_oe;
      @(negedge fast_clock);
      if (hold) begin
        cmd_op = nxt_op; cmd_data = nxt_data;
      end else begin
        cmd_valid = 1'b0;
      end
      while (r_cyc < LIMIT) begin
        if (left > 0) begin
          left--;
          if (left == 0) stretch = 1'b0;
        end
        if (scl_oe || sda_oe) r_any_oe = 1'b1;
        if (!bus_owned) r_owned_low++;
        if (sda_oe !== psda) begin
          if (scl_oe !== pscl) r_viol++;
          else if (!scl_oe && scl_in) begin
            if (sda_oe) r_starts++;
            else r_stops++;
          end
        end
        if (pscl && !scl_oe) begin
          rise++;
          if (rise <= 8) r_bits = {r_bits[6:0], ~sda_oe};
          if (rise == stretch_at) begin
            stretch = 1'b1;
            left = stretch_len;
          end
        end
        if (!pscl && scl_oe) begin
          fall++;
          if (fall == 8 && ack) slave_low = 1'b1;
          if (fall == 9) slave_low = 1'b0;
        end
        pscl = scl_oe;
        psda = sda_oe;
        if (done) begin
          r_done = 1'b1;
          r_err  = cmd_error;
          break;
        end
        if (cmd_ready) r_busy_ready++;
        @(negedge fast_clock);
        r_cyc++;
      end
    end
    slave_low = 1'b0;
    stretch   = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0;
    stretch = 1'b0; slave_low = 1'b0;
    repeat (3) @(negedge fast_clock);
    checks++;
    if ({scl_oe, sda_oe, cmd_ready, done, ack_n, cmd_error, bus_owned} !== 7'b0000100) begin
      failures++;
      $display("FAIL reset_values got=%b exp=0000100",
               {scl_oe, sda_oe, cmd_ready, done, ack_n, cmd_error, bus_owned});
    end
    reset_n = 1'b1;
    @(negedge fast_clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_idle_reject;
    logic seen;
    run_cmd(OP_WRITE, 8'h12, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    checks++;
    if ({r_done, r_err, r_any_oe} !== 3'b110 || r_cyc !== 0) begin
      failures++;
      $display("FAIL idle_write_reject done/err/oe=%b cyc=%0d exp=110 cyc=0",
               {r_done, r_err, r_any_oe}, r_cyc);
    end
    run_cmd(OP_STOP, 8'h00, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    checks++;
    if ({r_done, r_err, r_any_oe} !== 3'b110 || r_cyc !== 0) begin
      failures++;
      $display("FAIL idle_stop_reject done/err/oe=%b cyc=%0d exp=110 cyc=0",
               {r_done, r_err, r_any_oe}, r_cyc);
    end
    cmd_op = OP_NOP; cmd_valid = 1'b1;
    @(negedge fast_clock);
    cmd_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (done || scl_oe || sda_oe) seen = 1'b1;
      @(negedge fast_clock);
    end
    checks++;
    if (seen !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_nop activity=%b ready=%b exp activity=0 ready=1", seen, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_byte;
    int fall, n, w;
    logic p;
    run_cmd(OP_START, 8'h00, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    checks++;
    if (r_done !== 1'b1 || bus_owned !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_start done=%b owned=%b exp=1 1", r_done, bus_owned);
    end
    cmd_op = OP_WRITE; cmd_data = 8'hA5; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < LIMIT) begin
      @(negedge fast_clock);
      w++;
    end
    @(negedge fast_clock);
    cmd_valid = 1'b0;
    fall = 0; n = 0; p = scl_oe;
    while (fall < 3 && n < LIMIT) begin
      @(negedge fast_clock);
      n++;
      if (!p && scl_oe) fall++;
      p = scl_oe;
    end
    repeat (2) @(negedge fast_clock);
    checks++;
    if (fall !== 3 || {scl_oe, sda_oe} !== 2'b11) begin
      failures++;
      $display("FAIL mid_reset_bit4_drive falls=%0d scl/sda=%b exp falls=3 scl/sda=11",
               fall, {scl_oe, sda_oe});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({scl_oe, sda_oe, bus_owned} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_release scl/sda/owned=%b exp=000", {scl_oe, sda_oe, bus_owned});
    end
    @(negedge fast_clock);
    reset_n = 1'b1;
    @(negedge fast_clock);
    checks++;
    if (cmd_ready !== 1'b1 || bus_owned !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_after ready=%b owned=%b exp=1 0", cmd_ready, bus_owned);
    end
  endtask

  task automatic test_write_ack;
    int dones;
    dones = 0;
    run_cmd(OP_START, 8'h00, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    dones += int'(r_done);
    checks++;
    if (r_cyc !== 2*QP || r_err !== 1'b0 || r_starts !== 1 || bus_owned !== 1'b1) begin
      failures++;
      $display("FAIL start_timing cyc=%0d err=%b starts=%0d owned=%b exp cyc=%0d err=0 starts=1 owned=1",
               r_cyc, r_err, r_starts, bus_owned, 2*QP);
    end
    run_cmd(OP_WRITE, 8'hA5, 1'b1, 0, 0, 1'b0, OP_NOP, 8'h00);
    dones += int'(r_done);
    checks++;
    if (r_bits !== 8'hA5) begin
      failures++;
      $display("FAIL write_a5_bits got=%h exp=a5", r_bits);
    end
    checks++;
    if (r_cyc !== 36*QP) begin
      failures++;
      $display("FAIL write_a5_cycles got=%0d exp=%0d", r_cyc, 36*QP);
    end
    checks++;
    if ({ack_n, r_err} !== 2'b00 || r_viol !== 0 || r_starts + r_stops !== 0) begin
      failures++;
      $display("FAIL write_a5_ack ack_n/err=%b viol=%0d conds=%0d exp 00 0 0",
               {ack_n, r_err}, r_viol, r_starts + r_stops);
    end
    run_cmd(OP_STOP, 8'h00, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    dones += int'(r_done);
    checks++;
    if (r_cyc !== 3*QP || r_stops !== 1 || bus_owned !== 1'b0 || r_err !== 1'b0) begin
      failures++;
      $display("FAIL stop_timing cyc=%0d stops=%0d owned=%b err=%b exp cyc=%0d stops=1 owned=0 err=0",
               r_cyc, r_stops, bus_owned, r_err, 3*QP);
    end
    checks++;
    if (dones !== 3) begin
      failures++;
      $display("FAIL write_seq_dones got=%0d exp=3", dones);
    end
  endtask

  task automatic test_nack;
    run_cmd(OP_START, 8'h00, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    run_cmd(OP_WRITE, 8'hFF, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    checks++;
    if ({r_done, ack_n, r_err} !== 3'b110 || r_bits !== 8'hFF) begin
      failures++;
      $display("FAIL write_ff_nack done/ack_n/err=%b bits=%h exp=110 bits=ff",
               {r_done, ack_n, r_err}, r_bits);
    end
    checks++;
    if ({cmd_ready, bus_owned, scl_oe} !== 3'b111) begin
      failures++;
      $display("FAIL nack_hold ready/owned/scl=%b exp=111", {cmd_ready, bus_owned, scl_oe});
    end
  endtask

  task automatic test_stretch;
    run_cmd(OP_WRITE, 8'h5A, 1'b1, 5, 1000, 1'b0, OP_NOP, 8'h00);
    checks++;
    if (r_cyc !== 36*QP + 1000) begin
      failures++;
      $display("FAIL stretch_cycles got=%0d exp=%0d", r_cyc, 36*QP + 1000);
    end
    checks++;
    if (r_bits !== 8'h5A || ack_n !== 1'b0) begin
      failures++;
      $display("FAIL stretch_data bits=%h ack_n=%b exp bits=5a ack_n=0", r_bits, ack_n);
    end
    run_cmd(OP_STOP, 8'h00, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    checks++;
    if (bus_owned !== 1'b0 || {scl_oe, sda_oe} !== 2'b00) begin
      failures++;
      $display("FAIL stretch_stop owned=%b scl/sda=%b exp 0 00", bus_owned, {scl_oe, sda_oe});
    end
  endtask

  task automatic test_back_to_back;
    int starts, stops, busy, viol;
    starts = 0; stops = 0; busy = 0; viol = 0;
    run_cmd(OP_START, 8'h00, 1'b0, 0, 0, 1'b1, OP_WRITE, 8'h3C);
    starts += r_starts; stops += r_stops; busy += r_busy_ready; viol += r_viol;
    run_cmd(OP_WRITE, 8'h3C, 1'b1, 0, 0, 1'b1, OP_START, 8'h00);
    starts += r_starts; stops += r_stops; busy += r_busy_ready; viol += r_viol;
    checks++;
    if (r_bits !== 8'h3C || r_cyc !== 36*QP) begin
      failures++;
      $display("FAIL b2b_write_3c bits=%h cyc=%0d exp bits=3c cyc=%0d", r_bits, r_cyc, 36*QP);
    end
    run_cmd(OP_START, 8'h00, 1'b0, 0, 0, 1'b1, OP_WRITE, 8'h81);
    starts += r_starts; stops += r_stops; busy += r_busy_ready; viol += r_viol;
    checks++;
    if (r_cyc !== 4*QP || r_owned_low !== 0 || r_err !== 1'b0) begin
      failures++;
      $display("FAIL rstart cyc=%0d owned_low=%0d err=%b exp cyc=%0d owned_low=0 err=0",
               r_cyc, r_owned_low, r_err, 4*QP);
    end
    run_cmd(OP_WRITE, 8'h81, 1'b1, 0, 0, 1'b1, OP_STOP, 8'h00);
    starts += r_starts; stops += r_stops; busy += r_busy_ready; viol += r_viol;
    checks++;
    if (r_bits !== 8'h81 || ack_n !== 1'b0) begin
      failures++;
      $display("FAIL b2b_write_81 bits=%h ack_n=%b exp bits=81 ack_n=0", r_bits, ack_n);
    end
    run_cmd(OP_STOP, 8'h00, 1'b0, 0, 0, 1'b0, OP_NOP, 8'h00);
    starts += r_starts; stops += r_stops; busy += r_busy_ready; viol += r_viol;
    checks++;
    if (starts !== 2 || stops !== 1) begin
      failures++;
      $display("FAIL b2b_conditions starts=%0d stops=%0d exp starts=2 stops=1", starts, stops);
    end
    checks++;
    if (busy !== 0 || viol !== 0 || r_done !== 1'b1 || bus_owned !== 1'b0) begin
      failures++;
      $display("FAIL b2b_handshake busy_ready=%0d same_edge=%0d done=%b owned=%b exp 0 0 1 0",
               busy, viol, r_done, bus_owned);
    end
  endtask

  initial begin
    test_reset;
    test_idle_reject;
    test_reset_mid_byte;
    test_write_ack;
    test_nack;
    test_stretch;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
